// File: rtl/can_tx_frame_tail.sv
// Transmit-side sequencer for the CAN frame tail (CRC delimiter through Intermission).
// Keeps TX recessive, checks RX at each sample point and reports errors or completion.
module can_tx_frame_tail #(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       BIT_START,
  input  logic       SP,
  input  logic       START,
  input  logic       RX,
  output logic       TX,
  output logic       BUSY,
  output logic [2:0] FIELD,
  output logic       ACK_Error,
  output logic       FORM_Error,
  output logic       OVERLOAD,
  output logic       DONE
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CRC_DEL  = 3'd2,
    ST_ACK_SLOT = 3'd3,
    ST_ACK_DEL  = 3'd4,
    ST_EOF      = 3'd5,
    ST_IFS      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
  localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_BITS - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ack_next;
  logic             form_next;
  logic             ovl_next;
  logic             done_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      TX         <= 1'b1;
      BUSY       <= 1'b0;
      ACK_Error  <= 1'b0;
      FORM_Error <= 1'b0;
      OVERLOAD   <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      TX         <= 1'b1;
      BUSY       <= (state_next != ST_IDLE);
      ACK_Error  <= ack_next;
      FORM_Error <= form_next;
      OVERLOAD   <= ovl_next;
      DONE       <= done_next;
    end
  end

  assign FIELD = state;

  // Sample-point check uses the pre-advance state; any error aborts and masks the advance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack_next   = 1'b0;
    form_next  = 1'b0;
    ovl_next   = 1'b0;
    done_next  = 1'b0;

    if (SP) begin
      case (state)
        ST_CRC_DEL, ST_ACK_DEL, ST_EOF: form_next = ~RX;
        ST_ACK_SLOT:                    ack_next  = RX;
        ST_IFS:                         ovl_next  = ~RX && (cnt < IFS_LAST);
        default:                        ;
      endcase
    end

    if (ack_next || form_next || ovl_next) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state_next = ST_WAIT;
            cnt_next   = '0;
          end
        end
        ST_WAIT:     if (BIT_START) state_next = ST_CRC_DEL;
        ST_CRC_DEL:  if (BIT_START) state_next = ST_ACK_SLOT;
        ST_ACK_SLOT: if (BIT_START) state_next = ST_ACK_DEL;
        ST_ACK_DEL: begin
          if (BIT_START) begin
            state_next = ST_EOF;
            cnt_next   = '0;
          end
        end
        ST_EOF: begin
          if (BIT_START) begin
            if (cnt == EOF_LAST) begin
              state_next = ST_IFS;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end
        end
        ST_IFS: begin
          if (BIT_START) begin
            if (cnt == IFS_LAST) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              done_next  = 1'b1;
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_frame_tail.sv
// Randomized self-checking bench for can_tx_frame_tail; the reference model walks the
// tail as a list of bit positions and applies the per-field sample-point rules.
module tb_can_tx_frame_tail;

  localparam int EOF_BITS = 7;
  localparam int IFS_BITS = 3;
  localparam int NB       = 3 + EOF_BITS + IFS_BITS;

  localparam logic [8:0] IDLE_V = {3'd0, 2'b01, 4'b0000};
  localparam logic [8:0] DONE_V = {3'd0, 2'b01, 4'b0001};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       BIT_START, SP, START, RX;
  logic       TX, BUSY, ACK_Error, FORM_Error, OVERLOAD, DONE;
  logic [2:0] FIELD;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] obs;

  can_tx_frame_tail #(.EOF_BITS(EOF_BITS), .IFS_BITS(IFS_BITS), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .BIT_START(BIT_START), .SP(SP), .START(START), .RX(RX),
    .TX(TX), .BUSY(BUSY), .FIELD(FIELD), .ACK_Error(ACK_Error), .FORM_Error(FORM_Error),
    .OVERLOAD(OVERLOAD), .DONE(DONE)
  );

  always #5 clk = ~clk;

  // Field code of tail bit i: CRC_DEL, ACK_SLOT, ACK_DEL, EOF bits, then IFS bits.
  function automatic logic [2:0] field_of(input int i);
    if (i == 0) return 3'd2;
    if (i == 1) return 3'd3;
    if (i == 2) return 3'd4;
    if (i < 3 + EOF_BITS) return 3'd5;
    return 3'd6;
  endfunction

  // Expected {ack, form, overload} for sampling rx during tail bit i.
  function automatic logic [2:0] sp_outcome(input int i, input logic rx);
    case (field_of(i))
      3'd3:    return rx ? 3'b100 : 3'b000;
      3'd6:    return (!rx && i < NB - 1) ? 3'b001 : 3'b000;
      default: return rx ? 3'b000 : 3'b010;
    endcase
  endfunction

  function automatic logic [NB-1:0] nominal();
    logic [NB-1:0] r;
    r    = '1;
    r[1] = 1'b0;
    return r;
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic drive(input logic bs, input logic sp, input logic st, input logic rx);
    @(negedge clk);
    BIT_START = bs;
    SP        = sp;
    START     = st;
    RX        = rx;
    @(posedge clk);
    #1;
    obs = {FIELD, BUSY, TX, ACK_Error, FORM_Error, OVERLOAD, DONE};
  endtask

  task automatic run_frame(input logic [NB-1:0] rxv, input logic start_bs, input string name);
    logic [8:0] exp;
    logic [2:0] pul;
    repeat ($urandom_range(0, 2)) begin
      drive(rbit(), rbit(), 1'b0, rbit());
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("[TB] FAIL %s idle: got %b, expected %b", name, obs, IDLE_V);
      end
    end
    drive(start_bs, 1'b0, 1'b1, 1'b1);
    exp = {3'd1, 2'b11, 4'b0000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s start: got %b, expected %b", name, obs, exp);
    end
    for (int i = 0; i < NB; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      exp = {field_of(i), 2'b11, 4'b0000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s advance bit %0d: got %b, expected %b", name, i, obs, exp);
      end
      repeat ($urandom_range(0, 2)) begin
        drive(1'b0, 1'b0, rbit(), 1'b1);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL %s hold bit %0d: got %b, expected %b", name, i, obs, exp);
        end
      end
      drive(1'b0, 1'b1, 1'b0, rxv[i]);
      pul = sp_outcome(i, rxv[i]);
      if (pul != 3'b000) exp = {3'd0, 2'b01, pul, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s sample bit %0d: got %b, expected %b", name, i, obs, exp);
      end
      if (pul != 3'b000) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== IDLE_V) begin
          errors++;
          $display("[TB] FAIL %s post-abort: got %b, expected %b", name, obs, IDLE_V);
        end
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        drive(1'b0, 1'b0, rbit(), 1'b1);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL %s tail bit %0d: got %b, expected %b", name, i, obs, exp);
        end
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== DONE_V) begin
      errors++;
      $display("[TB] FAIL %s done: got %b, expected %b", name, obs, DONE_V);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("[TB] FAIL %s post-done: got %b, expected %b", name, obs, IDLE_V);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("[TB] FAIL reset: got %b, expected %b", obs, IDLE_V);
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b, expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_nominal();
    run_frame(nominal(), 1'b0, "nominal");
    run_frame(nominal(), 1'b1, "nominal_start_bs");
  endtask

  task automatic test_no_ack();
    logic [NB-1:0] r;
    r = nominal();
    r[1] = 1'b1;
    run_frame(r, 1'b0, "no_ack");
  endtask

  task automatic test_form_error();
    logic [NB-1:0] r;
    r = nominal(); r[0] = 1'b0; run_frame(r, 1'b0, "form_crc_del");
    r = nominal(); r[2] = 1'b0; run_frame(r, 1'b0, "form_ack_del");
    r = nominal(); r[6] = 1'b0; run_frame(r, 1'b0, "form_eof3");
  endtask

  task automatic test_ifs();
    logic [NB-1:0] r;
    r = nominal(); r[3 + EOF_BITS] = 1'b0;     run_frame(r, 1'b0, "overload_ifs0");
    r = nominal(); r[3 + EOF_BITS + 1] = 1'b0; run_frame(r, 1'b0, "overload_ifs1");
    r = nominal(); r[NB - 1] = 1'b0;           run_frame(r, 1'b0, "sof_last_ifs");
  endtask

  task automatic test_races();
    logic [8:0] exp;
    logic [3:0] bs_seq [10];
    logic [8:0] exp_seq [10];
    // Each entry is {BIT_START, SP, START, RX} with the state expected after that clock.
    bs_seq  = '{4'b0011, 4'b0011, 4'b1011, 4'b1100, 4'b0001,
                4'b1011, 4'b1001, 4'b1001, 4'b1100, 4'b1101};
    exp_seq = '{{3'd1, 6'b110000}, {3'd1, 6'b110000}, {3'd2, 6'b110000},
                {3'd0, 6'b010100}, IDLE_V, {3'd1, 6'b110000}, {3'd2, 6'b110000},
                {3'd3, 6'b110000}, {3'd4, 6'b110000}, {3'd5, 6'b110000}};
    for (int k = 0; k < 10; k++) begin
      drive(bs_seq[k][3], bs_seq[k][2], bs_seq[k][1], bs_seq[k][0]);
      checks++;
      if (obs !== exp_seq[k]) begin
        errors++;
        $display("[TB] FAIL races step %0d: got %b, expected %b", k, obs, exp_seq[k]);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp = {3'd0, 2'b01, 4'b0100};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL races eof_abort: got %b, expected %b", obs, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] exp;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b1);
    exp = {3'd5, 2'b11, 4'b0000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL reset_mid reach_eof: got %b, expected %b", obs, exp);
    end
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %b, expected %b", obs, IDLE_V);
    end
    reset_n = 1'b1;
    run_frame(nominal(), 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [NB-1:0] r;
    for (int n = 0; n < 40; n++) begin
      r = nominal();
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 14) == 0) r[b] = ~r[b];
      run_frame(r, rbit(), "random");
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    BIT_START = 1'b0;
    SP        = 1'b0;
    START     = 1'b0;
    RX        = 1'b1;
    test_reset();
    test_nominal();
    test_no_ack();
    test_form_error();
    test_ifs();
    test_races();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
